// File: rtl/data_stack.sv
// ----------------------------------------------------------------------------
// data_stack
//
// Purpose:
//   LIFO holding the Forth data-stack entries that sit below T. A push spills
//   the current T into the stack. A pop removes the top stored entry. The
//   registered N output always shows the top stored entry, or 0 when the
//   stack is empty. N feeds T_In for drop and binary operations.
//   All state changes on the falling edge of clk, the same edge as the
//   T register.
//
// Ports:
//   clk      in   1      system clock (state updates on the falling edge)
//   rst      in   1      synchronous active-high reset, sampled on falling edge
//   push     in   1      spill T onto the stack this cycle
//   pop      in   1      remove the top entry this cycle (push+pop = replace)
//   T        in   WIDTH  current top-of-stack value from the T register
//   err_clr  in   1      clears the sticky ovf/unf flags
//   N        out  WIDTH  next-of-stack value (top stored entry)
//   depth    out  CNT_W  number of valid entries, 0..DEPTH
//   empty    out  1      depth == 0
//   full     out  1      depth == DEPTH
//   ovf      out  1      sticky overflow flag
//   unf      out  1      sticky underflow flag
//
// Build option:
//   DSTACK_CIRC_EN - when defined, the stack is circular. A push while full
//   overwrites the oldest entry and advances a wrap-around base. ovf is never
//   set. When undefined, a push while full is ignored and sets ovf.
// ----------------------------------------------------------------------------
module data_stack #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] T,
   input  logic             err_clr,
   output logic [WIDTH-1:0] N,
   output logic [CNT_W-1:0] depth,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0]    IDX_ONE = AW'(1);
   localparam logic [AW-1:0]    IDX_TWO = AW'(2);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0] sp_q, sp_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   // Storage write port, decoded in the next-state logic.
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;

   // Physical slot of logical entry 0. It only moves in circular mode.
   logic [AW-1:0]    base;
`ifdef DSTACK_CIRC_EN
   logic [AW-1:0]    base_q, base_d;
   assign base = base_q;
`else
   assign base = '0;
`endif

   // ------------------------------------------------------------------------
   // Address arithmetic
   // ------------------------------------------------------------------------
   // All indices wrap modulo DEPTH. That is why the low AW bits of sp are
   // enough. When sp == DEPTH, sp[AW-1:0] is 0, so wr_idx lands back on base
   // (the oldest slot) and top_idx lands on base-1 (the newest slot).
   logic [AW-1:0] wr_idx;     // slot the next push writes
   logic [AW-1:0] top_idx;    // slot of the current top entry
   logic [AW-1:0] below_idx;  // slot of the entry under the top

   always_comb begin
      wr_idx    = base + sp_q[AW-1:0];
      top_idx   = wr_idx - IDX_ONE;
      below_idx = wr_idx - IDX_TWO;
   end

   // ------------------------------------------------------------------------
   // Status (combinational from sp)
   // ------------------------------------------------------------------------
   logic is_empty, is_full;

   assign is_empty = (sp_q == '0);
   assign is_full  = (sp_q == CNT_MAX);

   // ------------------------------------------------------------------------
   // Next-state decode
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      sp_d      = sp_q;
      n_d       = n_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      mem_we    = 1'b0;
      mem_waddr = wr_idx;
      mem_wdata = T;
`ifdef DSTACK_CIRC_EN
      base_d    = base_q;
`endif

      // Clear first, so an error event below in the same cycle wins.
      if (err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end

      if (push && pop && !is_empty) begin
         // Replace: overwrite the top entry in place, depth unchanged.
         mem_we    = 1'b1;
         mem_waddr = top_idx;
         n_d       = T;
      end else if (push) begin
         // Plain push. Push+pop on an empty stack also takes this path.
         if (!is_full) begin
            mem_we    = 1'b1;
            mem_waddr = wr_idx;
            sp_d      = sp_q + CNT_ONE;
            n_d       = T;
         end else begin
`ifdef DSTACK_CIRC_EN
            // wr_idx == base here, so the oldest entry is overwritten and
            // becomes the newest. Advancing base drops it from the bottom.
            mem_we    = 1'b1;
            mem_waddr = wr_idx;
            base_d    = base_q + IDX_ONE;
            n_d       = T;
`else
            ovf_d = 1'b1;
`endif
         end
      end else if (pop) begin
         if (!is_empty) begin
            sp_d = sp_q - CNT_ONE;
            // N moves to the new top on the same edge, so the consumer sees
            // it with no extra latency.
            n_d  = (sp_q >= CNT_TWO) ? mem_q[below_idx] : '0;
         end else begin
            unf_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. This way,
   // every register samples the values from before the edge.
   always_ff @(negedge clk) begin
      if (rst) begin
         sp_q   <= '0;
         n_q    <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
`ifdef DSTACK_CIRC_EN
         base_q <= '0;
`endif
      end else begin
         sp_q   <= sp_d;
         n_q    <= n_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
`ifdef DSTACK_CIRC_EN
         base_q <= base_d;
`endif
      end
   end

   // NOTE: the storage array has no reset. sp alone decides which entries
   // are valid, and leaving the array out of reset lets it map onto plain
   // RAM or flops without a reset tree.
   always_ff @(negedge clk) begin
      if (!rst && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign N     = n_q;
   assign depth = sp_q;
   assign empty = is_empty;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// ----------------------------------------------------------------------------
// tb_data_stack
//
// Directed bench for data_stack. It builds with WIDTH = 4 so that the values
// 1..8 in the fill sequence fit in a data word. The stack uses DEPTH = 8.
// Inputs are driven just after a falling edge. Outputs are sampled 1 time
// unit after the next falling edge.
// ----------------------------------------------------------------------------
module tb_data_stack;

   localparam int WIDTH = 4;
   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] t_in;
   logic             err_clr;
   logic [WIDTH-1:0] n_out;
   logic [CNT_W-1:0] depth;
   logic             empty;
   logic             full;
   logic             ovf;
   logic             unf;

   int checks = 0;
   int errors = 0;

   data_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .T       (t_in),
      .err_clr (err_clr),
      .N       (n_out),
      .depth   (depth),
      .empty   (empty),
      .full    (full),
      .ovf     (ovf),
      .unf     (unf)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs. Return just after the falling edge that
   // consumes them.
   task automatic cyc(input logic r, input logic ps, input logic pp,
                      input logic [WIDTH-1:0] t, input logic ec);
      rst     = r;
      push    = ps;
      pop     = pp;
      t_in    = t;
      err_clr = ec;
      @(negedge clk);
      #1;
      rst     = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_push(input logic [WIDTH-1:0] t);
      cyc(1'b0, 1'b1, 1'b0, t, 1'b0);
   endtask

   task automatic do_pop();
      cyc(1'b0, 1'b0, 1'b1, '0, 1'b0);
   endtask

   logic [WIDTH-1:0] pop_exp [8];

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; t_in = '0; err_clr = 1'b0;

      // Reset state
      do_reset();
      check("rst_depth", depth, 0);
      check("rst_n",     n_out, 0);
      check("rst_empty", empty, 1);
      check("rst_full",  full,  0);
      check("rst_ovf",   ovf,   0);
      check("rst_unf",   unf,   0);

      // Push 3,5,7, then pop
      do_push(4'd3);
      do_push(4'd5);
      do_push(4'd7);
      check("p3_depth", depth, 3);
      check("p3_n",     n_out, 7);
      check("p3_empty", empty, 0);
      do_pop();
      check("pop_n",     n_out, 5);
      check("pop_depth", depth, 2);

      // Fill to DEPTH, then a ninth push
      do_reset();
      for (int i = 1; i <= 8; i++) do_push(4'(i));
      check("fill_full",  full,  1);
      check("fill_depth", depth, 8);
      check("fill_n",     n_out, 8);
      do_push(4'd2);
      check("ovp_depth", depth, 8);
`ifdef DSTACK_CIRC_EN
      check("ovp_n",   n_out, 2);
      check("ovp_ovf", ovf,   0);
      pop_exp = '{4'd2, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2};
`else
      check("ovp_n",   n_out, 8);
      check("ovp_ovf", ovf,   1);
      // err_clr in the same cycle as another overflow: the error wins.
      cyc(1'b0, 1'b1, 1'b0, 4'd9, 1'b1);
      check("ovf_clr_race", ovf, 1);
      check("ovf_race_n",   n_out, 8);
      pop_exp = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
`endif
      // N holds the value being popped before each pop edge.
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_n%0d", i), n_out, pop_exp[i]);
         do_pop();
      end
      check("drain_depth", depth, 0);
      check("drain_empty", empty, 1);
      check("drain_n",     n_out, 0);
      check("drain_unf",   unf,   0);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("ovf_clr", ovf, 0);

      // Underflow and sticky clear
      do_reset();
      do_pop();
      check("unf_set",   unf,   1);
      check("unf_n",     n_out, 0);
      check("unf_depth", depth, 0);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("unf_clr", unf, 0);
      cyc(1'b0, 1'b0, 1'b1, '0, 1'b1);
      check("unf_clr_race", unf, 1);

      // Replace (push+pop)
      do_reset();
      do_push(4'd4);
      do_push(4'd6);
      cyc(1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
      check("repl_depth", depth, 2);
      check("repl_n",     n_out, 1);
      do_pop();
      check("repl_pop_n", n_out, 4);
      check("repl_pop_d", depth, 1);

      // Reset mid-operation overrides push
      do_reset();
      do_pop();                         // leaves unf set
      do_push(4'd1);
      do_push(4'd2);
      do_push(4'd3);
      cyc(1'b1, 1'b1, 1'b0, 4'd9, 1'b0);
      check("mid_rst_depth", depth, 0);
      check("mid_rst_n",     n_out, 0);
      check("mid_rst_ovf",   ovf,   0);
      check("mid_rst_unf",   unf,   0);
      do_push(4'd5);
      check("post_rst_n",     n_out, 5);
      check("post_rst_depth", depth, 1);

      // push+pop on an empty stack acts as a push
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 4'd6, 1'b0);
      check("pp_empty_depth", depth, 1);
      check("pp_empty_n",     n_out, 6);
      check("pp_empty_unf",   unf,   0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
